// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage. Owns the program counter, issues word
//             reads to a 1-cycle-latency synchronous instruction memory,
//             buffers returned words in a small prefetch queue and presents
//             them to decode over a valid/ready handshake. Handles branch
//             redirects and the halt word.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1   rising-edge clock
//    reset_n      in   1   synchronous active-low reset
//    imem_req     out  1   read request this cycle
//    imem_addr    out  16  read address (= pc)
//    imem_rdata   in   16  read data, valid 1 cycle after imem_req
//    redirect     in   1   load new PC, flush queue and in-flight read
//    redirect_pc  in   16  redirect target (bit 0 ignored)
//    ir_valid     out  1   queue head valid
//    ir_ready     in   1   decode accepts head this cycle
//    ir           out  16  head instruction word
//    ir_pc        out  16  address of head instruction
//    pc           out  16  next fetch address
//    halted       out  1   halt word seen and queue drained
// ============================================================================
module fetch_stage #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic [15:0] pc,
  output logic        halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               halted_q, halted_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        word_q [DEPTH];
  logic [15:0]        word_d [DEPTH];
  logic [15:0]        addr_q [DEPTH];
  logic [15:0]        addr_d [DEPTH];

  logic               head_valid;
  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ;

  assign head_valid = (count_q != '0);

  always_comb begin
    pop   = head_valid & ir_ready;
    // Slots that will be committed after this cycle; the issue rule keeps
    // count + inflight <= DEPTH so the queue can never overflow.
    occ   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue = reset_n & (state_q == ST_RUN) & ~redirect & (occ < OCC_W'(DEPTH));
    push  = inflight_q & ~redirect;

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    word_d     = word_q;
    addr_d     = addr_q;

    if (redirect) begin
      // Redirect wins over everything: flush queue and drop the in-flight read.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = redirect_pc & 16'hFFFE;
      state_d = ST_RUN;
    end else begin
      if (issue) begin
        pc_d       = pc_q + 16'd2;
        inflight_d = 1'b1;
        req_pc_d   = pc_q;
      end
      if (push) begin
        word_d[tail_q] = imem_rdata;
        addr_d[tail_q] = req_pc_q;
        tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
      end
      if (pop) begin
        head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
        ST_RUN: begin
          // Halt word is still enqueued; any read issued alongside it is
          // squashed and pc is rewound to just past the halt word.
          if (push && (imem_rdata == HALT_WORD)) begin
            state_d    = ST_HALT_PEND;
            pc_d       = req_pc_q + 16'd2;
            inflight_d = 1'b0;
          end
        end
        ST_HALT_PEND: begin
          if (count_q == '0) state_d = ST_HALTED;
        end
        ST_HALTED: begin
        end
        default: state_d = ST_RUN;
      endcase
    end

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign ir_valid  = head_valid;
  assign ir        = head_valid ? word_q[head_q] : 16'h0000;
  assign ir_pc     = head_valid ? addr_q[head_q] : 16'h0000;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage with a behavioural
//             1-cycle-latency instruction memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic [15:0] pc;
  logic        halted;

  logic [15:0] imem [32768];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .DEPTH     (2),
    .RESET_PC  (16'h0000),
    .HALT_WORD (16'hFFFF)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= imem[imem_addr[15:1]];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic saw_req;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ir_ready    = 1'b1;
    for (int i = 0; i < 32768; i++) imem[i] = 16'(i) ^ 16'h5A00;
    imem[0] = 16'h1111;
    imem[1] = 16'h2222;
    imem[2] = 16'h3333;

    // Reset state
    tick(); tick(); #1;
    chk("rst_ir_valid", 16'(ir_valid), 16'd0);
    chk("rst_ir",       ir,            16'h0000);
    chk("rst_ir_pc",    ir_pc,         16'h0000);
    chk("rst_halted",   16'(halted),   16'd0);
    chk("rst_imem_req", 16'(imem_req), 16'd0);
    chk("rst_pc",       pc,            16'h0000);

    // Streaming from reset, ready held high
    reset_n = 1'b1; #1;
    chk("t1_c0_req",  16'(imem_req), 16'd1);
    chk("t1_c0_addr", imem_addr,     16'h0000);
    tick(); #1;
    chk("t1_c1_valid", 16'(ir_valid), 16'd0);
    chk("t1_c1_addr",  imem_addr,     16'h0002);
    tick(); #1;
    chk("t1_c2_valid", 16'(ir_valid), 16'd1);
    chk("t1_c2_ir",    ir,            16'h1111);
    chk("t1_c2_pc",    ir_pc,         16'h0000);
    tick(); #1;
    chk("t1_c3_ir",    ir,            16'h2222);
    chk("t1_c3_pc",    ir_pc,         16'h0002);
    tick(); #1;
    chk("t1_c4_ir",    ir,            16'h3333);
    chk("t1_c4_pc",    ir_pc,         16'h0004);

    // Backpressure from reset: ready low for 5 cycles once the head is valid
    reset_n  = 1'b0;
    ir_ready = 1'b0;
    tick();
    reset_n = 1'b1; #1;
    chk("t2_c0_req", 16'(imem_req), 16'd1);
    tick(); #1;
    chk("t2_c1_req", 16'(imem_req), 16'd1);
    tick(); #1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_req", 16'(imem_req), 16'd0);
      chk("t2_hold_ir",  ir,            16'h1111);
      chk("t2_hold_pc",  ir_pc,         16'h0000);
      tick(); #1;
    end
    ir_ready = 1'b1; #1;
    chk("t2_rel_req",  16'(imem_req), 16'd1);
    chk("t2_rel_addr", imem_addr,     16'h0004);
    chk("t2_rel_ir",   ir,            16'h1111);
    tick(); #1;
    chk("t2_c8_ir",    ir,            16'h2222);
    chk("t2_c8_pc",    ir_pc,         16'h0002);
    tick(); #1;
    chk("t2_c9_ir",    ir,            16'h3333);
    chk("t2_c9_pc",    ir_pc,         16'h0004);

    // Redirect with a read in flight; bit 0 of the target is dropped
    redirect    = 1'b1;
    redirect_pc = 16'h0041; #1;
    chk("t3_redir_req", 16'(imem_req), 16'd0);
    tick();
    redirect = 1'b0; #1;
    chk("t3_r1_valid", 16'(ir_valid), 16'd0);
    chk("t3_r1_pc",    pc,            16'h0040);
    chk("t3_r1_addr",  imem_addr,     16'h0040);
    tick(); #1;
    chk("t3_r2_valid", 16'(ir_valid), 16'd0);
    tick(); #1;
    chk("t3_r3_valid", 16'(ir_valid), 16'd1);
    chk("t3_r3_pc",    ir_pc,         16'h0040);
    chk("t3_r3_ir",    ir,            16'h5A20);

    // Halt word at address 6
    imem[3]     = 16'hFFFF;
    redirect    = 1'b1;
    redirect_pc = 16'h0000; #1;
    tick();
    redirect = 1'b0; #1;
    tick(); tick(); #1;
    chk("t4_r3_ir", ir, 16'h1111);
    tick(); tick(); #1;
    chk("t4_r5_ir",  ir,            16'h3333);
    chk("t4_r5_req", 16'(imem_req), 16'd1);
    tick(); #1;
    chk("t4_halt_ir",  ir,            16'hFFFF);
    chk("t4_halt_pc",  ir_pc,         16'h0006);
    chk("t4_halt_req", 16'(imem_req), 16'd0);
    chk("t4_halt_fpc", pc,            16'h0008);
    saw_req = 1'b0;
    for (int k = 0; k < 8 && !halted; k++) begin
      if (imem_req) saw_req = 1'b1;
      tick(); #1;
    end
    chk("t4_halted",    16'(halted),   16'd1);
    chk("t4_no_req",    16'(saw_req),  16'd0);
    chk("t4_pc_frozen", pc,            16'h0008);
    chk("t4_empty",     16'(ir_valid), 16'd0);

    // Redirect out of HALTED
    redirect    = 1'b1;
    redirect_pc = 16'h0000; #1;
    chk("t5_still_halted", 16'(halted), 16'd1);
    tick();
    redirect = 1'b0; #1;
    chk("t5_halted", 16'(halted),   16'd0);
    chk("t5_pc",     pc,            16'h0000);
    chk("t5_req",    16'(imem_req), 16'd1);
    tick(); tick(); #1;
    chk("t5_ir",     ir,            16'h1111);
    chk("t5_ir_pc",  ir_pc,         16'h0000);

    // PC wrap at 0xFFFE, then reset mid-stream
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE; #1;
    tick();
    redirect = 1'b0; #1;
    chk("t6_addr_fffe", imem_addr,     16'hFFFE);
    chk("t6_req_fffe",  16'(imem_req), 16'd1);
    tick(); #1;
    chk("t6_addr_wrap", imem_addr,     16'h0000);
    tick(); #1;
    chk("t6_ir_pc",     ir_pc,         16'hFFFE);
    chk("t6_ir",        ir,            16'h25FF);
    reset_n = 1'b0;
    tick(); #1;
    chk("t6_rst_valid", 16'(ir_valid), 16'd0);
    chk("t6_rst_pc",    pc,            16'h0000);
    chk("t6_rst_req",   16'(imem_req), 16'd0);
    reset_n = 1'b1; #1;
    chk("t6_c0_valid",  16'(ir_valid), 16'd0);
    tick(); #1;
    chk("t6_c1_valid",  16'(ir_valid), 16'd0);
    tick(); #1;
    chk("t6_c2_ir",     ir,            16'h1111);
    chk("t6_c2_pc",     ir_pc,         16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
